// File: rtl/cnt_event_mon.sv
// cnt_event_mon: downstream monitor for the load/increment counter.
// It samples the counter value every clock and classifies each new value as a
// MATCH against a compare value, a WRAP (all-ones -> 0) or an unexpected JUMP.
// Detected events go into a small FIFO that is drained through a valid/ready port.
// Event encoding: ev_data = {type[1:0], value}; type 00=MATCH, 01=WRAP, 10=JUMP.
// Optional build macro CNT_EVENT_MON_PARITY_EN: adds an even-parity MSB, the XOR
// of {type,value}, which is stored with each entry.
module cnt_event_mon #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [CNT_W-1:0]        cnt_data,
    input  logic                    cnt_wr,
    input  logic [CNT_W-1:0]        cmp_val,
    input  logic                    cmp_en,
    output logic                    ev_valid,
    input  logic                    ev_ready,
`ifdef CNT_EVENT_MON_PARITY_EN
    output logic [CNT_W+2:0]        ev_data,
`else
    output logic [CNT_W+1:0]        ev_data,
`endif
    output logic [$clog2(DEPTH):0]  ev_count,
    output logic                    ev_ovf,
    output logic [7:0]              drop_cnt
);

    localparam int AW = $clog2(DEPTH);
`ifdef CNT_EVENT_MON_PARITY_EN
    localparam int EW = CNT_W + 3;
`else
    localparam int EW = CNT_W + 2;
`endif
    localparam logic [AW:0] FULL_CNT   = (AW+1)'(DEPTH);
    localparam logic [1:0]  TYPE_MATCH = 2'b00;
    localparam logic [1:0]  TYPE_WRAP  = 2'b01;
    localparam logic [1:0]  TYPE_JUMP  = 2'b10;

    logic [CNT_W-1:0] prev;
    logic             prev_valid;
    logic             wr_d;
    logic [CNT_W-1:0] prev_inc;
    logic             jump_det;
    logic             wrap_det;
    logic             match_det;
    logic             push;
    logic [1:0]       ev_type;
    logic [EW-1:0]    ev_entry;

    logic [EW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             pop;
    logic             accept;
    logic             drop;

    // Remember the previous sample and the load strobe that produced the current one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev       <= '0;
            prev_valid <= 1'b0;
            wr_d       <= 1'b0;
        end else begin
            prev       <= cnt_data;
            prev_valid <= 1'b1;
            wr_d       <= cnt_wr;
        end
    end

    // Classify the current sample; a load suppresses JUMP only, priority JUMP > WRAP > MATCH
    always_comb begin
        prev_inc  = prev + 1'b1;
        jump_det  = prev_valid && (cnt_data != prev_inc) && (cnt_data != prev) && !wr_d;
        wrap_det  = prev_valid && (prev == {CNT_W{1'b1}}) && (cnt_data == '0);
        match_det = prev_valid && cmp_en && (cnt_data == cmp_val) && (prev != cmp_val);
        push      = jump_det || wrap_det || match_det;
        if (jump_det) begin
            ev_type = TYPE_JUMP;
        end else if (wrap_det) begin
            ev_type = TYPE_WRAP;
        end else begin
            ev_type = TYPE_MATCH;
        end
`ifdef CNT_EVENT_MON_PARITY_EN
        ev_entry = {^{ev_type, cnt_data}, ev_type, cnt_data};
`else
        ev_entry = {ev_type, cnt_data};
`endif
    end

    // FIFO control: a pop frees a slot in the same cycle, so full+pop still accepts a push
    always_comb begin
        full   = (count == FULL_CNT);
        pop    = (count != '0) && ev_ready;
        accept = push && (!full || pop);
        drop   = push && full && !pop;
    end

    // Event storage; contents are only observed through valid entries, so no reset needed
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= ev_entry;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Overflow bookkeeping: sticky flag plus a saturating count of dropped events
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ev_ovf   <= 1'b0;
            drop_cnt <= 8'd0;
        end else if (drop) begin
            ev_ovf <= 1'b1;
            if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // Output port: head entry when valid, zero otherwise
    always_comb begin
        ev_valid = (count != '0);
        ev_count = count;
        ev_data  = ev_valid ? mem[rd_ptr] : '0;
    end

endmodule

// File: tb/tb_cnt_event_mon.sv
// tb_cnt_event_mon: directed, table-driven bench for cnt_event_mon (DEPTH=4, CNT_W=8).
// Honours CNT_EVENT_MON_PARITY_EN when defined for the build.
module tb_cnt_event_mon;

`ifdef CNT_EVENT_MON_PARITY_EN
    localparam int EW = 11;
`else
    localparam int EW = 10;
`endif

    logic          clk;
    logic          reset;
    logic [7:0]    cnt_data;
    logic          cnt_wr;
    logic [7:0]    cmp_val;
    logic          cmp_en;
    logic          ev_valid;
    logic          ev_ready;
    logic [EW-1:0] ev_data;
    logic [2:0]    ev_count;
    logic          ev_ovf;
    logic [7:0]    drop_cnt;

    int checks;
    int errors;

    typedef struct {
        string         name;
        logic [7:0]    data;
        logic          wr;
        logic [7:0]    cval;
        logic          cen;
        logic          exp_valid;
        logic [EW-1:0] exp_data;
        int            exp_count;
    } vec_t;

    vec_t vecs[$];

    cnt_event_mon #(.DEPTH(4), .CNT_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .cnt_data (cnt_data),
        .cnt_wr   (cnt_wr),
        .cmp_val  (cmp_val),
        .cmp_en   (cmp_en),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_data  (ev_data),
        .ev_count (ev_count),
        .ev_ovf   (ev_ovf),
        .drop_cnt (drop_cnt)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected event word built from type and value, with parity when enabled
    function automatic logic [EW-1:0] mk(input logic [1:0] t, input logic [7:0] v);
`ifdef CNT_EVENT_MON_PARITY_EN
        return {^{t, v}, t, v};
`else
        return {t, v};
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic addVec(input string name, input logic [7:0] data, input logic wr,
                          input logic [7:0] cval, input logic cen, input logic ev,
                          input logic [EW-1:0] ed, input int ec);
        vec_t v;
        v.name = name; v.data = data; v.wr = wr; v.cval = cval; v.cen = cen;
        v.exp_valid = ev; v.exp_data = ed; v.exp_count = ec;
        vecs.push_back(v);
    endtask

    // Drive one sample, let the edge take it, and settle just after the edge
    task automatic applyStimulus(input logic [7:0] data, input logic wr);
        cnt_data = data;
        cnt_wr   = wr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        cnt_data = 8'h00;
        cnt_wr   = 1'b0;
        cmp_val  = 8'h00;
        cmp_en   = 1'b0;
        ev_ready = 1'b1;

        // Table: ev_ready=1 throughout, so each event is visible for exactly one cycle
        addVec("t1_seed",    8'h10, 0, 8'h05, 0, 0, '0, 0);
        addVec("t1_inc11",   8'h11, 0, 8'h05, 0, 0, '0, 0);
        addVec("t1_inc12",   8'h12, 0, 8'h05, 0, 0, '0, 0);
        addVec("t2_load",    8'h12, 1, 8'h05, 1, 0, '0, 0);
        addVec("t2_03",      8'h03, 0, 8'h05, 1, 0, '0, 0);
        addVec("t2_04",      8'h04, 0, 8'h05, 1, 0, '0, 0);
        addVec("t2_match",   8'h05, 0, 8'h05, 1, 1, mk(2'b00, 8'h05), 1);
        addVec("t2_hold05",  8'h05, 0, 8'h05, 1, 0, '0, 0);
        addVec("t2_06",      8'h06, 0, 8'h05, 1, 0, '0, 0);
        addVec("t3_load",    8'h06, 1, 8'h00, 1, 0, '0, 0);
        addVec("t3_FE",      8'hFE, 0, 8'h00, 1, 0, '0, 0);
        addVec("t3_FF",      8'hFF, 0, 8'h00, 1, 0, '0, 0);
        addVec("t3_wrap",    8'h00, 0, 8'h00, 1, 1, mk(2'b01, 8'h00), 1);
        addVec("t3_01",      8'h01, 0, 8'h00, 1, 0, '0, 0);
        addVec("t4_load",    8'h01, 1, 8'h00, 0, 0, '0, 0);
        addVec("t4_20",      8'h20, 0, 8'h00, 0, 0, '0, 0);
        addVec("t4_jump40",  8'h40, 0, 8'h00, 0, 1, mk(2'b10, 8'h40), 1);
        addVec("t4_hold40",  8'h40, 1, 8'h00, 0, 0, '0, 0);
        addVec("t4_20wr",    8'h20, 1, 8'h00, 0, 0, '0, 0);
        addVec("t4_40sup",   8'h40, 0, 8'h00, 0, 0, '0, 0);
        addVec("pri_jump",   8'h80, 0, 8'h80, 1, 1, mk(2'b10, 8'h80), 1);
        addVec("pri_81",     8'h81, 0, 8'h80, 1, 0, '0, 0);

        // Reset state
        #1;
        checkOutput("rst_valid", ev_valid, 0);
        checkOutput("rst_count", ev_count, 0);
        checkOutput("rst_data",  ev_data, 0);
        checkOutput("rst_ovf",   ev_ovf, 0);
        checkOutput("rst_drop",  drop_cnt, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (vecs[i]) begin
            cmp_val = vecs[i].cval;
            cmp_en  = vecs[i].cen;
            applyStimulus(vecs[i].data, vecs[i].wr);
            checkOutput({vecs[i].name, "_valid"}, ev_valid, vecs[i].exp_valid);
            checkOutput({vecs[i].name, "_count"}, ev_count, vecs[i].exp_count);
            if (vecs[i].exp_valid) begin
                checkOutput({vecs[i].name, "_data"}, ev_data, vecs[i].exp_data);
            end
        end

        // Overflow: six JUMPs into a 4-deep FIFO with the consumer stalled
        begin
            logic [7:0] jv [6];
            int         ec [6];
            jv = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
            ec = '{1, 2, 3, 4, 4, 4};
            cmp_en   = 1'b0;
            ev_ready = 1'b0;
            for (int i = 0; i < 6; i++) begin
                applyStimulus(jv[i], 1'b0);
                checkOutput($sformatf("ovf_count%0d", i), ev_count, ec[i]);
                checkOutput($sformatf("ovf_flag%0d", i), ev_ovf, (i >= 4) ? 1 : 0);
                checkOutput($sformatf("ovf_drop%0d", i), drop_cnt, (i >= 4) ? i - 3 : 0);
                checkOutput($sformatf("ovf_head%0d", i), ev_data, mk(2'b10, 8'h10));
            end
            ev_ready = 1'b1;
            for (int i = 0; i < 4; i++) begin
                checkOutput($sformatf("drain_valid%0d", i), ev_valid, 1);
                checkOutput($sformatf("drain_data%0d", i), ev_data, mk(2'b10, jv[i]));
                applyStimulus(8'h60, 1'b0);
            end
            checkOutput("drain_done_valid", ev_valid, 0);
            checkOutput("drain_done_count", ev_count, 0);
            checkOutput("drain_ovf_sticky", ev_ovf, 1);
            checkOutput("drain_drop_kept", drop_cnt, 2);
        end

        // Full with simultaneous pop: push accepted, count unchanged, no drop
        ev_ready = 1'b0;
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h03, 1'b0);
        applyStimulus(8'h05, 1'b0);
        applyStimulus(8'h07, 1'b0);
        checkOutput("fullpop_pre_count", ev_count, 4);
        ev_ready = 1'b1;
        applyStimulus(8'h09, 1'b0);
        checkOutput("fullpop_count", ev_count, 4);
        checkOutput("fullpop_drop",  drop_cnt, 2);
        checkOutput("fullpop_head",  ev_data, mk(2'b10, 8'h03));
        applyStimulus(8'h09, 1'b0);
        checkOutput("pop3_count", ev_count, 3);
        checkOutput("pop3_head",  ev_data, mk(2'b10, 8'h05));
        ev_ready = 1'b0;

        // Asynchronous reset mid-cycle with three entries queued
        #2;
        reset = 1'b1;
        #1;
        checkOutput("arst_valid", ev_valid, 0);
        checkOutput("arst_count", ev_count, 0);
        checkOutput("arst_ovf",   ev_ovf, 0);
        checkOutput("arst_drop",  drop_cnt, 0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        ev_ready = 1'b1;
        applyStimulus(8'h77, 1'b0);
        checkOutput("reseed_valid", ev_valid, 0);
        applyStimulus(8'h78, 1'b0);
        checkOutput("reseed_inc_valid", ev_valid, 0);
        applyStimulus(8'h90, 1'b0);
        checkOutput("post_jump_valid", ev_valid, 1);
        checkOutput("post_jump_data",  ev_data, mk(2'b10, 8'h90));
`ifdef CNT_EVENT_MON_PARITY_EN
        checkOutput("post_jump_parity", ev_data[EW-1], 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
